// File: rtl/fpu.sv
`timescale 1ns/1ps
// fpu: half-precision (binary16) add/sub/mul unit behind a UART link.
// A 6-byte command frame (A lo/hi, B lo/hi, OP lo/hi) arrives on rx, and the
// 16-bit result goes back on tx, low byte first. Subnormals flush to zero.
// Rounding is round-to-nearest-even.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   rx    - UART receive line, 8N1, idle high
//   tx    - UART transmit line, 8N1, idle high
//   ready - high while idle and able to accept a new frame
//   error - exception/framing flag of the last frame; cleared at next frame start
module fpu #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  output logic ready,
  output logic error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_RECV, T_COMPUTE, T_SEND_LO, T_SEND_HI} top_state_t;

  // Leading-zero count of a 14-bit value (14 when the value is zero).
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    n = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) n = 4'(13 - i);
    end
    return n;
  endfunction

  // Round a normalised significand {hidden, frac[9:0], guard, round, sticky}
  // to nearest-even and pack it. Bit 16 of the return value flags overflow.
  function automatic logic [16:0] round_pack(input logic s,
                                             input logic signed [7:0] e,
                                             input logic [13:0] m);
    logic             inc;
    logic [11:0]      r;
    logic signed [7:0] e2;
    logic [16:0]      res;
    inc = m[2] & (m[1] | m[0] | m[3]);
    r   = {1'b0, m[13:3]} + {11'd0, inc};
    e2  = e;
    if (r[11]) begin
      r  = r >> 1;
      e2 = e + 8'sd1;
    end
    if (e2 > 8'sd30)     res = {1'b1, s, 5'h1F, 10'h000};
    else if (e2 < 8'sd1) res = 17'h0;
    else                 res = {1'b0, s, e2[4:0], r[9:0]};
    return res;
  endfunction

  // ---------------- state ----------------
  logic                rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t           rxs_q, rxs_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;
  logic [2:0]          rbit_q, rbit_d;
  logic [7:0]          rsh_q, rsh_d;
  logic                rx_start_ok, rx_byte_vld, rx_ferr;

  tx_state_t           txs_q, txs_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic [2:0]          tbit_q, tbit_d;
  logic [7:0]          tsh_q, tsh_d;
  logic                tx_q, tx_d;
  logic                tx_go, tx_done;
  logic [7:0]          tx_byte;

  top_state_t          top_q, top_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic [15:0]         a_q, a_d, b_q, b_d, op_q, op_d, res_q, res_d;
  logic                err_q, err_d;

  logic [15:0]         calc_res;
  logic                calc_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rxs_q     <= RX_IDLE;
      rcnt_q    <= '0;
      rbit_q    <= '0;
      rsh_q     <= '0;
      txs_q     <= TX_IDLE;
      tcnt_q    <= '0;
      tbit_q    <= '0;
      tsh_q     <= '0;
      tx_q      <= 1'b1;
      top_q     <= T_IDLE;
      bcnt_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rxs_q     <= rxs_d;
      rcnt_q    <= rcnt_d;
      rbit_q    <= rbit_d;
      rsh_q     <= rsh_d;
      txs_q     <= txs_d;
      tcnt_q    <= tcnt_d;
      tbit_q    <= tbit_d;
      tsh_q     <= tsh_d;
      tx_q      <= tx_d;
      top_q     <= top_d;
      bcnt_q    <= bcnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  // ---------------- UART receiver ----------------
  always_comb begin
    rxs_d       = rxs_q;
    rcnt_d      = rcnt_q;
    rbit_d      = rbit_q;
    rsh_d       = rsh_q;
    rx_start_ok = 1'b0;
    rx_byte_vld = 1'b0;
    rx_ferr     = 1'b0;
    unique case (rxs_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rxs_d  = RX_START;
          rcnt_d = '0;
        end
      end
      RX_START: begin
        // Re-check the line half a bit in so a short glitch is not taken as a start bit.
        if (rcnt_q == HALF_LAST) begin
          rcnt_d = '0;
          rbit_d = '0;
          if (!rx_s2_q) begin
            rxs_d       = RX_DATA;
            rx_start_ok = 1'b1;
          end else begin
            rxs_d = RX_IDLE;
          end
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rcnt_q == BIT_LAST) begin
          rcnt_d = '0;
          rsh_d  = {rx_s2_q, rsh_q[7:1]};
          if (rbit_q == 3'd7) rxs_d = RX_STOP;
          else                rbit_d = rbit_q + 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rcnt_q == BIT_LAST) begin
          rcnt_d = '0;
          rxs_d  = RX_IDLE;
          if (rx_s2_q) rx_byte_vld = 1'b1;
          else         rx_ferr     = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: rxs_d = RX_IDLE;
    endcase
  end

  // ---------------- UART transmitter ----------------
  // tx_done fires in the last cycle of the stop bit; a tx_go in that same cycle
  // starts the next byte with no idle gap.
  always_comb begin
    txs_d   = txs_q;
    tcnt_d  = tcnt_q;
    tbit_d  = tbit_q;
    tsh_d   = tsh_q;
    tx_done = 1'b0;
    unique case (txs_q)
      TX_IDLE: ;
      TX_START: begin
        if (tcnt_q == BIT_LAST) begin
          tcnt_d = '0;
          tbit_d = '0;
          txs_d  = TX_DATA;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tcnt_q == BIT_LAST) begin
          tcnt_d = '0;
          tsh_d  = tsh_q >> 1;
          if (tbit_q == 3'd7) txs_d = TX_STOP;
          else                tbit_d = tbit_q + 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tcnt_q == BIT_LAST) begin
          tcnt_d  = '0;
          txs_d   = TX_IDLE;
          tx_done = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: txs_d = TX_IDLE;
    endcase
    if (tx_go) begin
      txs_d  = TX_START;
      tcnt_d = '0;
      tsh_d  = tx_byte;
    end
    // Line level follows the next state so tx is registered and glitch-free.
    unique case (txs_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tsh_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // ---------------- arithmetic ----------------
  logic              sa, sb, sb_eff, sx, swap, eff_sub;
  logic [4:0]        ea, eb, ex, ey, ed;
  logic [10:0]       ma, mb, mx, my;
  logic [23:0]       al_sh;
  logic [13:0]       al_y, a_nrm, m_nrm;
  logic [14:0]       sum;
  logic [3:0]        lz;
  logic signed [7:0] a_exp, m_exp;
  logic [21:0]       prod;
  logic [16:0]       add_rp, mul_rp;

  always_comb begin
    sa      = a_q[15];
    sb      = b_q[15];
    ea      = a_q[14:10];
    eb      = b_q[14:10];
    // Subnormal inputs flush to zero: no hidden bit, fraction dropped.
    ma      = (ea == 5'd0) ? 11'd0 : {1'b1, a_q[9:0]};
    mb      = (eb == 5'd0) ? 11'd0 : {1'b1, b_q[9:0]};
    sb_eff  = sb ^ op_q[0];
    eff_sub = sa ^ sb_eff;
    swap    = {eb, mb} > {ea, ma};
    sx      = swap ? sb_eff : sa;
    ex      = swap ? eb : ea;
    mx      = swap ? mb : ma;
    ey      = swap ? ea : eb;
    my      = swap ? ma : mb;
    ed      = ex - ey;
    al_sh   = '0;
    lz      = '0;

    // Add/sub: align the smaller operand keeping guard, round and sticky bits.
    if (ed > 5'd13) begin
      al_y = {13'd0, |my};
    end else begin
      al_sh = {my, 13'd0} >> ed;
      al_y  = {al_sh[23:11], |al_sh[10:0]};
    end
    sum = eff_sub ? ({1'b0, mx, 3'd0} - {1'b0, al_y})
                  : ({1'b0, mx, 3'd0} + {1'b0, al_y});
    if (sum[14]) begin
      a_nrm = {sum[14:2], sum[1] | sum[0]};
      a_exp = $signed({3'd0, ex}) + 8'sd1;
    end else begin
      lz    = lzc14(sum[13:0]);
      a_nrm = sum[13:0] << lz;
      a_exp = $signed({3'd0, ex}) - $signed({4'd0, lz});
    end
    add_rp = round_pack(sx, a_exp, a_nrm);
    if (sum == 15'd0) add_rp = 17'd0;

    // Mul: product of two [1,2) significands lies in [1,4), so at most one right shift.
    prod  = {11'd0, ma} * {11'd0, mb};
    m_exp = $signed({3'd0, ea}) + $signed({3'd0, eb}) - 8'sd15;
    if (prod[21]) begin
      m_nrm = {prod[21:9], |prod[8:0]};
      m_exp = m_exp + 8'sd1;
    end else begin
      m_nrm = {prod[20:8], |prod[7:0]};
    end
    mul_rp = round_pack(sa ^ sb, m_exp, m_nrm);
    if (ea == 5'd0 || eb == 5'd0) mul_rp = {1'b0, sa ^ sb, 15'd0};

    if (op_q > 16'd2 || ea == 5'h1F || eb == 5'h1F) begin
      calc_err = 1'b1;
      calc_res = 16'h7E00;
    end else if (op_q == 16'd2) begin
      calc_err = mul_rp[16];
      calc_res = mul_rp[15:0];
    end else begin
      calc_err = add_rp[16];
      calc_res = add_rp[15:0];
    end
  end

  // ---------------- command/response sequencer ----------------
  always_comb begin
    top_d   = top_q;
    bcnt_d  = bcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    tx_go   = 1'b0;
    tx_byte = 8'h00;
    unique case (top_q)
      T_IDLE: begin
        if (rx_start_ok) begin
          top_d  = T_RECV;
          bcnt_d = '0;
          err_d  = 1'b0;
        end
      end
      T_RECV: begin
        if (rx_ferr) begin
          top_d  = T_IDLE;
          bcnt_d = '0;
          err_d  = 1'b1;
        end else if (rx_byte_vld) begin
          unique case (bcnt_q)
            3'd0:    a_d[7:0]   = rsh_q;
            3'd1:    a_d[15:8]  = rsh_q;
            3'd2:    b_d[7:0]   = rsh_q;
            3'd3:    b_d[15:8]  = rsh_q;
            3'd4:    op_d[7:0]  = rsh_q;
            default: op_d[15:8] = rsh_q;
          endcase
          if (bcnt_q == 3'd5) begin
            top_d  = T_COMPUTE;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      T_COMPUTE: begin
        res_d   = calc_res;
        err_d   = err_q | calc_err;
        tx_go   = 1'b1;
        tx_byte = calc_res[7:0];
        top_d   = T_SEND_LO;
      end
      T_SEND_LO: begin
        if (tx_done) begin
          tx_go   = 1'b1;
          tx_byte = res_q[15:8];
          top_d   = T_SEND_HI;
        end
      end
      T_SEND_HI: begin
        if (tx_done) top_d = T_IDLE;
      end
      default: top_d = T_IDLE;
    endcase
  end

  assign tx    = tx_q;
  assign ready = (top_q == T_IDLE);
  assign error = err_q;

endmodule

// File: tb/tb_fpu.sv
`timescale 1ns/1ps
// Directed bench for fpu: drives UART command frames and decodes the reply.
module tb_fpu;

  localparam int CPB = 16;
  localparam int TMO = 100 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic tx, ready, error;

  int n_checks = 0;
  int n_errors = 0;

  fpu #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .tx    (tx),
    .ready (ready),
    .error (error)
  );

  always #10 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit first);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    if (first) begin
      check("ready_fall", 32'(ready), 32'd0);
      check("err_clear", 32'(error), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  // bad_idx selects a byte whose stop bit is forced low; the frame is abandoned after it.
  task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] op, input int bad_idx);
    logic [47:0] fr;
    bit abort;
    fr = {op, b, a};
    abort = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!abort) begin
        send_byte(fr[8*k +: 8], k != bad_idx, k == 0);
        if (k == bad_idx) abort = 1'b1;
      end
    end
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok);
    int n;
    b  = 8'h00;
    ok = 1'b0;
    n  = 0;
    while (tx !== 1'b0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      ok = (tx === 1'b1);
    end
  endtask

  task automatic recv_word(output logic [15:0] w, output bit ok);
    logic [7:0] lo, hi;
    bit ok1, ok2;
    hi  = 8'h00;
    ok2 = 1'b0;
    recv_byte(lo, ok1);
    if (ok1) recv_byte(hi, ok2);
    w  = {hi, lo};
    ok = ok1 & ok2;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] op, input logic [15:0] exp_res,
                           input bit exp_err);
    logic [15:0] got;
    bit ok;
    fork
      send_frame(a, b, op, 6);
      recv_word(got, ok);
    join
    check({tag, "_res"}, ok ? 32'(got) : 32'hFFFF_FFFF, 32'(exp_res));
    repeat (CPB / 2 + 3) @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_err"}, 32'(error), 32'(exp_err));
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    bit saw_low;
    bit found;
    int n;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b1;
    repeat (4 * CPB) @(negedge clk);

    run_frame("mul",      16'h5780, 16'h3D05, 16'h0002, 16'h58B5, 1'b0);
    run_frame("add",      16'h5780, 16'h3D05, 16'h0000, 16'h5794, 1'b0);
    run_frame("sub",      16'h5780, 16'h3D05, 16'h0001, 16'h576C, 1'b0);
    run_frame("badop",    16'h5780, 16'h3D05, 16'h0003, 16'h7E00, 1'b1);
    run_frame("ovf",      16'h7BFF, 16'h7BFF, 16'h0002, 16'h7C00, 1'b1);
    run_frame("ovf_neg",  16'hFBFF, 16'h7BFF, 16'h0002, 16'hFC00, 1'b1);
    run_frame("inf_in",   16'h7C00, 16'h3D05, 16'h0000, 16'h7E00, 1'b1);

    // Stop bit of byte 2 forced low: frame dropped, no reply.
    saw_low = 1'b0;
    fork
      send_frame(16'h5780, 16'h3D05, 16'h0002, 2);
      begin
        for (int i = 0; i < 40 * CPB; i++) begin
          @(negedge clk);
          if (tx !== 1'b1) saw_low = 1'b1;
        end
      end
    join
    check("ferr_tx_idle", 32'(saw_low), 32'd0);
    check("ferr_error", 32'(error), 32'd1);
    check("ferr_ready", 32'(ready), 32'd1);

    run_frame("recover",  16'h5780, 16'h3D05, 16'h0002, 16'h58B5, 1'b0);
    run_frame("sub_zero", 16'h3C00, 16'h3C00, 16'h0001, 16'h0000, 1'b0);
    run_frame("mul_rne",  16'h3C01, 16'h3C01, 16'h0002, 16'h3C02, 1'b0);
    run_frame("add_ulp",  16'h3C00, 16'h1400, 16'h0000, 16'h3C01, 1'b0);
    run_frame("mul_zero", 16'h8000, 16'h3C00, 16'h0002, 16'h8000, 1'b0);

    // Asynchronous reset while the reply is on the wire (error already set).
    found = 1'b0;
    fork
      send_frame(16'h5780, 16'h3D05, 16'h0003, 6);
      begin
        n = 0;
        while (tx !== 1'b0 && n < TMO) begin
          @(negedge clk);
          n++;
        end
        found = (tx === 1'b0);
        repeat (3 * CPB) @(negedge clk);
        #3 rst = 1'b0;
        #2;
        check("arst_tx", 32'(tx), 32'd1);
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_error", 32'(error), 32'd0);
        #8 rst = 1'b1;
      end
    join
    check("arst_reply_started", 32'(found), 32'd1);
    saw_low = 1'b0;
    for (int i = 0; i < 4 * CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("arst_tx_quiet", 32'(saw_low), 32'd0);
    check("arst_ready_after", 32'(ready), 32'd1);
    check("arst_error_after", 32'(error), 32'd0);

    run_frame("post_rst", 16'h5780, 16'h3D05, 16'h0002, 16'h58B5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
